// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: control-field bit positions and FSM encoding shared by the MEM/WB stage
package mem_wb_stage_pkg;
  localparam int MEM_BRANCH = 3;
  localparam int MEM_READ = 2;
  localparam int MEM_WRITE = 1;
  localparam int MEM_BNE = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: req/ack data-memory bus; master is the stage, slave is the memory
interface mem_wb_stage_if #(parameter int ADDR_W = 32);
  logic DmemReq;
  logic DmemWe;
  logic [ADDR_W-1:0] DmemAddr;
  logic [31:0] DmemWdata;
  logic [31:0] DmemRdata;
  logic DmemAck;
  modport master (output DmemReq, DmemWe, DmemAddr, DmemWdata, input DmemRdata, DmemAck);
  modport slave (input DmemReq, DmemWe, DmemAddr, DmemWdata, output DmemRdata, DmemAck);
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; read data loads only on rdLoad, bubble zeroes write-back control
module mem_wb_reg (
  input  logic clk,
  input  logic reset,
  input  logic rdLoad,
  input  logic bubble,
  input  logic [31:0] rdata,
  input  logic [31:0] result,
  input  logic [4:0] wrReg,
  input  logic [1:0] wb,
  output logic [31:0] ReadDataReg,
  output logic [31:0] ResultWBReg,
  output logic [4:0] WrRegWBReg,
  output logic [1:0] WBWBReg
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ReadDataReg <= '0;
      ResultWBReg <= '0;
      WrRegWBReg <= '0;
      WBWBReg <= '0;
    end else begin
      if (rdLoad) ReadDataReg <= rdata;
      ResultWBReg <= result;
      WrRegWBReg <= wrReg;
      WBWBReg <= bubble ? 2'b00 : wb;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage with req/ack data-memory handshake, branch resolve and MEM/WB register.
// Define MEM_TIMEOUT_EN to add an access watchdog that aborts hung accesses and raises a sticky MemFault.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic [31:0] Result,
  input  logic [31:0] OutB,
  input  logic Equal,
  input  logic [4:0] WrReg,
  input  logic [3:0] MEM,
  input  logic [1:0] WB,
  input  logic Mem_WB_Flush_excep,
  mem_wb_stage_if.master dmem,
  output logic PCSrc,
  output logic Stall,
  output logic MisalignExcep,
  output logic [31:0] ReadDataReg,
  output logic [31:0] ResultWBReg,
  output logic [4:0] WrRegWBReg,
  output logic [1:0] WBWBReg,
  output logic MemFault
);
  state_t state, nextState;
  logic memop, misaligned, ackHit, timeout, reqNext, weNext;
  assign memop = MEM[MEM_READ] | MEM[MEM_WRITE];
  assign misaligned = memop & (Result[1:0] != 2'b00);
  assign PCSrc = MEM[MEM_BRANCH] & (Equal ^ MEM[MEM_BNE]);
  assign ackHit = (state == ACCESS) & dmem.DmemAck;
  assign Stall = memop & !misaligned & !(ackHit | timeout);
  assign dmem.DmemAddr = Result[ADDR_W-1:0];
  assign dmem.DmemWdata = OutB;
`ifdef MEM_TIMEOUT_EN
  logic [31:0] waitCnt;
  assign timeout = (state == ACCESS) & !dmem.DmemAck & (waitCnt == 32'(TIMEOUT_CYCLES - 1));
  // counter idles at zero so it is already clear on entry to ACCESS
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      waitCnt <= '0;
      MemFault <= 1'b0;
    end else begin
      waitCnt <= (state == ACCESS) ? waitCnt + 32'd1 : '0;
      MemFault <= MemFault | timeout;
    end
`else
  assign timeout = 1'b0;
  assign MemFault = 1'b0;
`endif
  always_comb begin
    nextState = state;
    reqNext = dmem.DmemReq;
    weNext = dmem.DmemWe;
    if (state == IDLE) begin
      if (memop & !misaligned) begin
        nextState = ACCESS;
        reqNext = 1'b1;
        weNext = MEM[MEM_WRITE];
      end
    end else if (dmem.DmemAck | timeout) begin
      nextState = IDLE;
      reqNext = 1'b0;
      weNext = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      dmem.DmemReq <= 1'b0;
      dmem.DmemWe <= 1'b0;
      MisalignExcep <= 1'b0;
    end else begin
      state <= nextState;
      dmem.DmemReq <= reqNext;
      dmem.DmemWe <= weNext;
      MisalignExcep <= (state == IDLE) & misaligned;
    end
  mem_wb_reg u_reg (
    .clk(clk),
    .reset(reset),
    .rdLoad(ackHit),
    .bubble(Stall | misaligned | timeout | Mem_WB_Flush_excep),
    .rdata(dmem.DmemRdata),
    .result(Result),
    .wrReg(WrReg),
    .wb({WB[WB_REGWRITE], WB[WB_MEMTOREG]}),
    .ReadDataReg(ReadDataReg),
    .ResultWBReg(ResultWBReg),
    .WrRegWBReg(WrRegWBReg),
    .WBWBReg(WBWBReg)
  );
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: instruction-level reference model of the MEM/WB stage driven by directed and random traffic
module tb_mem_wb_stage;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] Result = '0, OutB = '0;
  logic Equal = 1'b0, flushExcep = 1'b0;
  logic [4:0] WrReg = '0;
  logic [3:0] MEM = '0;
  logic [1:0] WB = '0;
  logic PCSrc, Stall, MisalignExcep, MemFault;
  logic [31:0] ReadDataReg, ResultWBReg;
  logic [4:0] WrRegWBReg;
  logic [1:0] WBWBReg;
  int total = 0, bad = 0;
  logic [31:0] expRd = '0;
  logic expFault = 1'b0;
  mem_wb_stage_if #(.ADDR_W(32)) dmem ();
  always #5 clk = ~clk;
  mem_wb_stage #(
    .ADDR_W(32)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) dut (
    .clk(clk), .reset(reset), .Result(Result), .OutB(OutB), .Equal(Equal), .WrReg(WrReg),
    .MEM(MEM), .WB(WB), .Mem_WB_Flush_excep(flushExcep), .dmem(dmem.master),
    .PCSrc(PCSrc), .Stall(Stall), .MisalignExcep(MisalignExcep), .ReadDataReg(ReadDataReg),
    .ResultWBReg(ResultWBReg), .WrRegWBReg(WrRegWBReg), .WBWBReg(WBWBReg), .MemFault(MemFault)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic postChk(input bit excep);
    chk("misalign", MisalignExcep, excep);
    chk("readdata", ReadDataReg, expRd);
    chk("memfault", MemFault, expFault);
  endtask
  // one instruction held at EX/MEM until the stage lets it go; lat = no-ack ACCESS cycles before the ack
  task automatic runInstr(input logic [3:0] m, input logic [1:0] w, input logic [31:0] res,
                          input logic [4:0] wr, input logic eq, input logic fl, input int lat,
                          input logic [31:0] rd);
    bit isMem, mis, spurious;
    isMem = m[2] | m[1];
    mis = isMem && res[1:0] != 2'b00;
    MEM = m; WB = w; Result = res; OutB = $urandom; WrReg = wr; Equal = eq; flushExcep = fl;
    #1;
    chk("pcsrc", PCSrc, m[3] & (eq ^ m[0]));
    if (isMem && !mis) begin
      chk("stall_issue", Stall, 1);
      chk("req_issue", dmem.DmemReq, 0);
      tick;
      postChk(0);
      for (int k = 0; k <= lat; k++) begin
        bit ack, to;
        ack = (k == lat);
        to = TO_EN && !ack && k == TO - 1;
        chk("req_acc", dmem.DmemReq, 1);
        chk("we_acc", dmem.DmemWe, m[1]);
        chk("addr", dmem.DmemAddr, res);
        chk("wdata", dmem.DmemWdata, OutB);
        chk("wb_bubble", WBWBReg, 0);
        dmem.DmemAck = ack;
        dmem.DmemRdata = ack ? rd : $urandom;
        #1;
        chk("stall_acc", Stall, !(ack || to));
        tick;
        dmem.DmemAck = 1'b0;
        if (ack || to) begin
          chk("req_done", dmem.DmemReq, 0);
          if (ack) begin
            expRd = rd;
            chk("wb_mem", WBWBReg, fl ? 2'b00 : w);
            chk("result_mem", ResultWBReg, res);
            chk("wrreg_mem", WrRegWBReg, wr);
          end else begin
            expFault = 1'b1;
            chk("wb_timeout", WBWBReg, 0);
          end
          postChk(0);
          break;
        end
        postChk(0);
      end
    end else if (mis) begin
      chk("stall_mis", Stall, 0);
      tick;
      chk("req_mis", dmem.DmemReq, 0);
      chk("wb_mis", WBWBReg, 0);
      postChk(1);
    end else begin
      spurious = ($urandom_range(0, 3) == 0);
      dmem.DmemAck = spurious;
      dmem.DmemRdata = $urandom;
      #1;
      chk("stall_alu", Stall, 0);
      tick;
      dmem.DmemAck = 1'b0;
      chk("req_alu", dmem.DmemReq, 0);
      chk("wb_alu", WBWBReg, fl ? 2'b00 : w);
      chk("result_alu", ResultWBReg, res);
      chk("wrreg_alu", WrRegWBReg, wr);
      postChk(0);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    dmem.DmemAck = 1'b0;
    dmem.DmemRdata = '0;
    #12;
    chk("rst_req", dmem.DmemReq, 0);
    chk("rst_we", dmem.DmemWe, 0);
    chk("rst_wb", WBWBReg, 0);
    chk("rst_result", ResultWBReg, 0);
    chk("rst_wrreg", WrRegWBReg, 0);
    postChk(0);
    @(negedge clk) reset = 1'b0;
    tick;
    runInstr(4'b0000, 2'b10, 32'h1234, 5'd5, 0, 0, 0, 0);
    runInstr(4'b0100, 2'b11, 32'h40, 5'd3, 0, 0, 3, 32'hDEADBEEF);
    runInstr(4'b0010, 2'b00, 32'h41, 5'd0, 0, 0, 0, 0);
    runInstr(4'b1000, 2'b00, 32'h0, 5'd0, 1, 0, 0, 0);
    runInstr(4'b1001, 2'b00, 32'h0, 5'd0, 1, 0, 0, 0);
    runInstr(4'b0000, 2'b11, 32'h55, 5'd7, 0, 1, 0, 0);
    runInstr(4'b0100, 2'b11, 32'h80, 5'd9, 0, 1, 1, 32'hCAFEF00D);
    runInstr(4'b0010, 2'b00, 32'h84, 5'd0, 0, 0, 0, 32'h0);
    if (TO_EN) runInstr(4'b0100, 2'b11, 32'hC0, 5'd4, 0, 0, 20, 32'h1111);
    // asynchronous reset while an access is outstanding
    MEM = 4'b0100; WB = 2'b11; Result = 32'h100; flushExcep = 1'b0;
    tick;
    chk("pre_rst_req", dmem.DmemReq, 1);
    #3 reset = 1'b1;
    #1;
    expRd = '0;
    expFault = 1'b0;
    chk("midrst_req", dmem.DmemReq, 0);
    chk("midrst_wb", WBWBReg, 0);
    postChk(0);
    MEM = 4'b0000; WB = 2'b00;
    @(negedge clk) reset = 1'b0;
    dmem.DmemAck = 1'b1;
    dmem.DmemRdata = 32'hBAD0BAD0;
    tick;
    dmem.DmemAck = 1'b0;
    chk("postrst_req", dmem.DmemReq, 0);
    postChk(0);
    runInstr(4'b0110, 2'b01, 32'h200, 5'd2, 0, 0, 2, 32'h600DD00D);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] res;
      res = $urandom;
      if ($urandom_range(0, 3) != 0) res[1:0] = 2'b00;
      runInstr(4'($urandom), 2'($urandom), res, 5'($urandom), 1'($urandom), $urandom_range(0, 7) == 0,
               $urandom_range(0, TO_EN ? 6 : 3), $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
